// File: rtl/ldst_step_sequencer.sv
// Moore control-step sequencer for ld/ldi/st: fetch T0-T2, execute T3-T7, memory steps stretched by MEM_LAT.
// Optional single-step mode: define SEQ_SINGLE_STEP_EN to add a 'step' input gating every T-state transition.
module ldst_step_sequencer #(
  parameter int                MEM_LAT = 1,
  parameter int                OPC_W   = 5,
  parameter logic [OPC_W-1:0]  ADD_OPC = 5'b00011
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [31:0]      ir,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic             PC_out,
  output logic             MAR_enable,
  output logic             IncPC,
  output logic             PC_enable,
  output logic             Read,
  output logic             MDR_enable,
  output logic             MDR_out,
  output logic             IR_enable,
  output logic             Gra,
  output logic             Grb,
  output logic             R_in,
  output logic             R_out,
  output logic             BA_out,
  output logic             Y_enable,
  output logic             C_out,
  output logic             Z_enable,
  output logic             ZLow_out,
  output logic             RAM_write_enable,
  output logic [OPC_W-1:0] opcode
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_DONE = 4'd9
  } state_t;

  localparam logic [OPC_W-1:0] OPC_LD  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_LDI = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_ST  = OPC_W'(2);
  localparam logic [3:0]       CNT_INIT = 4'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             illegal_q, illegal_d;
  logic             adv;
  logic [OPC_W-1:0] ir_opc;
  logic             unused_ir_bits;

  assign ir_opc         = ir[31 -: OPC_W];
  assign unused_ir_bits = ^ir[31-OPC_W:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      opc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opc_q     <= opc_d;
      illegal_q <= illegal_d;
    end
  end

  // Held steps leave when the wait counter has run down to zero.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    opc_d            = opc_q;
    illegal_d        = illegal_q;
    PC_out           = 1'b0;
    MAR_enable       = 1'b0;
    IncPC            = 1'b0;
    PC_enable        = 1'b0;
    Read             = 1'b0;
    MDR_enable       = 1'b0;
    MDR_out          = 1'b0;
    IR_enable        = 1'b0;
    Gra              = 1'b0;
    Grb              = 1'b0;
    R_in             = 1'b0;
    R_out            = 1'b0;
    BA_out           = 1'b0;
    Y_enable         = 1'b0;
    C_out            = 1'b0;
    Z_enable         = 1'b0;
    ZLow_out         = 1'b0;
    RAM_write_enable = 1'b0;
    done             = 1'b0;
    opcode           = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_T0;
          illegal_d = 1'b0;
        end
      end
      S_T0: begin
        PC_out     = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        PC_enable  = 1'b1;
        if (adv) begin
          state_d = S_T1;
          cnt_d   = CNT_INIT;
        end
      end
      S_T1: begin
        Read       = 1'b1;
        MDR_enable = 1'b1;
        if (adv) begin
          if (cnt_q == 4'd0) state_d = S_T2;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      S_T2: begin
        MDR_out   = 1'b1;
        IR_enable = 1'b1;
        if (adv) state_d = S_T3;
      end
      S_T3: begin
        Grb      = 1'b1;
        BA_out   = 1'b1;
        Y_enable = 1'b1;
        if (adv) begin
          opc_d = ir_opc;
          if (ir_opc == OPC_LD || ir_opc == OPC_LDI || ir_opc == OPC_ST) begin
            state_d = S_T4;
          end else begin
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_T4: begin
        C_out    = 1'b1;
        Z_enable = 1'b1;
        opcode   = ADD_OPC;
        if (adv) state_d = S_T5;
      end
      S_T5: begin
        ZLow_out = 1'b1;
        if (opc_q == OPC_LDI) begin
          Gra  = 1'b1;
          R_in = 1'b1;
          if (adv) state_d = S_DONE;
        end else begin
          MAR_enable = 1'b1;
          if (adv) begin
            state_d = S_T6;
            cnt_d   = CNT_INIT;
          end
        end
      end
      // ld reads memory here; st instead places the source register into MDR.
      S_T6: begin
        MDR_enable = 1'b1;
        if (opc_q == OPC_LD) begin
          Read = 1'b1;
          if (adv) begin
            if (cnt_q == 4'd0) state_d = S_T7;
            else               cnt_d   = cnt_q - 4'd1;
          end
        end else begin
          Gra   = 1'b1;
          R_out = 1'b1;
          if (adv) begin
            state_d = S_T7;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_T7: begin
        if (opc_q == OPC_LD) begin
          MDR_out = 1'b1;
          Gra     = 1'b1;
          R_in    = 1'b1;
          if (adv) state_d = S_DONE;
        end else begin
          RAM_write_enable = 1'b1;
          if (adv) begin
            if (cnt_q == 4'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 4'd1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ldst_step_sequencer.sv
// Directed bench: three sequencers (MEM_LAT 1, 2, 3) driven by hand-built per-cycle state/strobe tables.
module tb_ldst_step_sequencer;

  // Strobe bit order: 0 PC_out, 1 MAR_enable, 2 IncPC, 3 PC_enable, 4 Read, 5 MDR_enable,
  // 6 MDR_out, 7 IR_enable, 8 Gra, 9 Grb, 10 R_in, 11 R_out, 12 BA_out, 13 Y_enable,
  // 14 C_out, 15 Z_enable, 16 ZLow_out, 17 RAM_write_enable
  localparam logic [17:0] M_NONE   = 18'h00000;
  localparam logic [17:0] M_T0     = 18'h0000F;
  localparam logic [17:0] M_READ   = 18'h00030;
  localparam logic [17:0] M_T2     = 18'h000C0;
  localparam logic [17:0] M_T3     = 18'h03200;
  localparam logic [17:0] M_T4     = 18'h0C000;
  localparam logic [17:0] M_T5MEM  = 18'h10002;
  localparam logic [17:0] M_T5LDI  = 18'h10500;
  localparam logic [17:0] M_T6ST   = 18'h00920;
  localparam logic [17:0] M_T7LD   = 18'h00540;
  localparam logic [17:0] M_T7ST   = 18'h20000;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        start1, start2, start3;

  wire         busy1, done1, ill1;
  wire         busy2, done2, ill2;
  wire         busy3, done3, ill3;
  wire  [3:0]  st1, st2, st3;
  wire  [4:0]  opc1, opc2, opc3;
  wire  [17:0] str1, str2, str3;

  int checks = 0;
  int errors = 0;

  logic [3:0]  expS[$];
  logic [17:0] expM[$];

  always #5 clk = ~clk;

  ldst_step_sequencer #(.MEM_LAT(1)) u1 (
    .clk(clk), .clr(clr), .start(start1), .ir(ir),
    .busy(busy1), .done(done1), .illegal(ill1), .state_o(st1),
    .PC_out(str1[0]), .MAR_enable(str1[1]), .IncPC(str1[2]), .PC_enable(str1[3]),
    .Read(str1[4]), .MDR_enable(str1[5]), .MDR_out(str1[6]), .IR_enable(str1[7]),
    .Gra(str1[8]), .Grb(str1[9]), .R_in(str1[10]), .R_out(str1[11]), .BA_out(str1[12]),
    .Y_enable(str1[13]), .C_out(str1[14]), .Z_enable(str1[15]), .ZLow_out(str1[16]),
    .RAM_write_enable(str1[17]), .opcode(opc1)
  );

  ldst_step_sequencer #(.MEM_LAT(2)) u2 (
    .clk(clk), .clr(clr), .start(start2), .ir(ir),
    .busy(busy2), .done(done2), .illegal(ill2), .state_o(st2),
    .PC_out(str2[0]), .MAR_enable(str2[1]), .IncPC(str2[2]), .PC_enable(str2[3]),
    .Read(str2[4]), .MDR_enable(str2[5]), .MDR_out(str2[6]), .IR_enable(str2[7]),
    .Gra(str2[8]), .Grb(str2[9]), .R_in(str2[10]), .R_out(str2[11]), .BA_out(str2[12]),
    .Y_enable(str2[13]), .C_out(str2[14]), .Z_enable(str2[15]), .ZLow_out(str2[16]),
    .RAM_write_enable(str2[17]), .opcode(opc2)
  );

  ldst_step_sequencer #(.MEM_LAT(3)) u3 (
    .clk(clk), .clr(clr), .start(start3), .ir(ir),
    .busy(busy3), .done(done3), .illegal(ill3), .state_o(st3),
    .PC_out(str3[0]), .MAR_enable(str3[1]), .IncPC(str3[2]), .PC_enable(str3[3]),
    .Read(str3[4]), .MDR_enable(str3[5]), .MDR_out(str3[6]), .IR_enable(str3[7]),
    .Gra(str3[8]), .Grb(str3[9]), .R_in(str3[10]), .R_out(str3[11]), .BA_out(str3[12]),
    .Y_enable(str3[13]), .C_out(str3[14]), .Z_enable(str3[15]), .ZLow_out(str3[16]),
    .RAM_write_enable(str3[17]), .opcode(opc3)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setStart(input int inst, input logic v);
    case (inst)
      1:       start1 = v;
      2:       start2 = v;
      default: start3 = v;
    endcase
  endtask

  // Busy, done and opcode expectations follow from the expected state alone.
  task automatic checkInst(input int inst, input string tag, input logic [3:0] s,
                           input logic [17:0] m, input logic ill);
    logic [3:0]  os;
    logic [17:0] om;
    logic        ob, od, oi;
    logic [4:0]  oo;
    case (inst)
      1:       begin os = st1; om = str1; ob = busy1; od = done1; oi = ill1; oo = opc1; end
      2:       begin os = st2; om = str2; ob = busy2; od = done2; oi = ill2; oo = opc2; end
      default: begin os = st3; om = str3; ob = busy3; od = done3; oi = ill3; oo = opc3; end
    endcase
    checkVal({tag, " state"},   32'(os), 32'(s));
    checkVal({tag, " strobes"}, 32'(om), 32'(m));
    checkVal({tag, " busy"},    32'(ob), 32'(s != 4'd0));
    checkVal({tag, " done"},    32'(od), 32'(s == 4'd9));
    checkVal({tag, " opcode"},  32'(oo), (s == 4'd5) ? 32'd3 : 32'd0);
    checkVal({tag, " illegal"}, 32'(oi), 32'(ill));
  endtask

  task automatic runSeq(input int inst, input string name, input logic [31:0] irVal,
                        input int holdN, input logic illRun);
    ir = irVal;
    setStart(inst, 1'b1);
    for (int i = 0; i < expS.size(); i++) begin
      @(negedge clk);
      if (i + 1 >= holdN) setStart(inst, 1'b0);
      checkInst(inst, $sformatf("%s c%0d", name, i), expS[i], expM[i],
                illRun && (expS[i] == 4'd9 || expS[i] == 4'd0));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 1'b0;
    ir = 32'd0;
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkInst(1, "por u1", 4'd0, M_NONE, 1'b0);
    checkInst(2, "por u2", 4'd0, M_NONE, 1'b0);
    checkInst(3, "por u3", 4'd0, M_NONE, 1'b0);
    clr = 1'b1;
    @(negedge clk);

    $display("[TB] ld, MEM_LAT=1");
    expS = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    expM = '{M_T0, M_READ, M_T2, M_T3, M_T4, M_T5MEM, M_READ, M_T7LD, M_NONE, M_NONE};
    runSeq(1, "ld1", 32'h0090_0055, 1, 1'b0);

    $display("[TB] ld, MEM_LAT=3, start held into T1");
    expS = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd7, 4'd8, 4'd9, 4'd0};
    expM = '{M_T0, M_READ, M_READ, M_READ, M_T2, M_T3, M_T4, M_T5MEM,
             M_READ, M_READ, M_READ, M_T7LD, M_NONE, M_NONE};
    runSeq(3, "ld3", 32'h0090_0055, 3, 1'b0);

    $display("[TB] st, MEM_LAT=2");
    expS = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd9, 4'd0};
    expM = '{M_T0, M_READ, M_READ, M_T2, M_T3, M_T4, M_T5MEM, M_T6ST,
             M_T7ST, M_T7ST, M_NONE, M_NONE};
    runSeq(2, "st2", 32'h1188_0087, 1, 1'b0);

    $display("[TB] illegal opcode, MEM_LAT=1, start during DONE");
    expS = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9};
    expM = '{M_T0, M_READ, M_T2, M_T3, M_NONE};
    runSeq(1, "ill1", 32'hF800_0000, 1, 1'b1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checkInst(1, "ill1 done-start", 4'd0, M_NONE, 1'b1);
    @(negedge clk);
    checkInst(1, "ill1 sticky", 4'd0, M_NONE, 1'b1);

    $display("[TB] ldi, MEM_LAT=1, clears illegal");
    expS = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd0};
    expM = '{M_T0, M_READ, M_T2, M_T3, M_T4, M_T5LDI, M_NONE, M_NONE};
    runSeq(1, "ldi1", 32'h0890_0055, 1, 1'b0);

    $display("[TB] illegal opcode, MEM_LAT=2");
    expS = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd9, 4'd0};
    expM = '{M_T0, M_READ, M_READ, M_T2, M_T3, M_NONE, M_NONE};
    runSeq(2, "ill2", 32'hF800_0000, 1, 1'b1);

    $display("[TB] asynchronous reset during T6 of ld");
    ir = 32'h0090_0055;
    start1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    checkInst(1, "pre-rst", 4'd7, M_READ, 1'b0);
    #1 clr = 1'b0;
    #1;
    checkInst(1, "rst u1", 4'd0, M_NONE, 1'b0);
    checkInst(2, "rst u2", 4'd0, M_NONE, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    expS = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    expM = '{M_T0, M_READ, M_T2, M_T3, M_T4, M_T5MEM, M_READ, M_T7LD, M_NONE, M_NONE};
    runSeq(1, "ld1 post-rst", 32'h0090_0055, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
